// File: rtl/s_z_reader.sv
// rtl/s_z_reader.sv - result-memory readout sweep with 2-entry skid FIFO and valid/ready stream.
// Optional S_Z_READER_LAST_EN adds last_o flagging the final word of each burst.

module s_z_reader_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = entry[rd_ptr];

endmodule

module s_z_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic [ADDR_WIDTH-1:0] read_addr_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
`ifdef S_Z_READER_LAST_EN
    ,
    output logic                  last_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   length_q;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   pop_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  inflight;
    logic                  issue;
    logic                  pop;
    logic                  issue_last;
    logic                  pop_last;
    logic [1:0]            fifo_count;
    logic [2:0]            occupancy;

    // Credit rule: words held plus words in flight, net of this cycle's pop, must stay below 2.
    assign pop        = valid_o & ready_i;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue_last = (issue_cnt + CNT_ONE) == length_q;
    assign pop_last   = (pop_cnt + CNT_ONE) == length_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (length_i == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue && issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && pop_last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            READ: begin
                busy_o = 1'b1;
                issue  = occupancy < 3'd2;
            end
            DRAIN:   busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length_q  <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            addr_q    <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (state == IDLE && start_i) begin
                length_q  <= length_i;
                issue_cnt <= '0;
                pop_cnt   <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + CNT_ONE;
                    addr_q    <= issue_cnt[ADDR_WIDTH-1:0];
                end
                if (pop) begin
                    pop_cnt <= pop_cnt + CNT_ONE;
                end
            end
        end
    end

    // Address is only meaningful on issue; between issues it parks on the last issued word.
    assign read_addr_o = issue ? issue_cnt[ADDR_WIDTH-1:0] : addr_q;

    s_z_reader_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (read_data_i),
        .pop       (pop),
        .head      (data_o),
        .count     (fifo_count)
    );

    assign valid_o = fifo_count != 2'd0;

`ifdef S_Z_READER_LAST_EN
    assign last_o = valid_o && (pop_cnt == (length_q - CNT_ONE));
`endif

endmodule

// File: tb/tb_s_z_reader.sv
// tb/tb_s_z_reader.sv - table-driven scoreboard bench for s_z_reader.

module tb_s_z_reader;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [AW:0]   length = '0;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic [DW-1:0] data;
    logic          valid;
    logic          busy;
    logic          done;
`ifdef S_Z_READER_LAST_EN
    logic          last;
`endif

    s_z_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .length_i    (length),
        .read_addr_o (read_addr),
        .read_data_i (read_data),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .busy_o      (busy),
        .done_o      (done)
`ifdef S_Z_READER_LAST_EN
        ,
        .last_o      (last)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    always @(posedge clk) read_data <= mem[read_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] exp_q [$];
    bit mon_en = 1'b0;
    int t0, rx, cur_len, first_valid, done_cnt, done_off, busy_seen, max_ahead;

    typedef struct {
        int len;
        int mode;
        int restart_off;
        int exp_done;
        int exp_first;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k >= 9 && k <= 12) ? 1'b0 : (k % 2 == 0);
            2:       return !(k == 5 || k == 6);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            int off;
            int ahead;
            off = cyc - t0;
            if (busy) busy_seen = 1;
            if (valid && first_valid < 0) first_valid = off;
            if (done) begin
                done_cnt++;
                done_off = off;
            end
`ifdef S_Z_READER_LAST_EN
            if (valid) check("last_o", int'(last), int'(rx == cur_len - 1));
`endif
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL word: got unexpected 0x%0h, expected no further word", data);
                end else begin
                    check("word", int'(data), int'(exp_q.pop_front()));
                end
                rx++;
            end
            if (busy) begin
                ahead = int'(read_addr) + 1 - rx;
                if (ahead > max_ahead) max_ahead = ahead;
            end
        end
    end

    task automatic begin_burst(input int len);
        start     = 1'b1;
        length    = (AW + 1)'(len);
        t0        = cyc;
        rx        = 0;
        cur_len   = len;
        first_valid = -1;
        done_cnt  = 0;
        done_off  = -1;
        busy_seen = 0;
        max_ahead = 0;
        for (int i = 0; i < len; i++) exp_q.push_back(16'h0A00 + 16'(i));
        mon_en = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        begin_burst(v.len);
        ready = ready_for(v.mode, 0);
        for (int k = 1; k < 400 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            start  = (v.restart_off == k);
            length = (v.restart_off == k) ? (AW + 1)'(3) : (AW + 1)'(v.len);
            ready  = ready_for(v.mode, k);
        end
        start = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check($sformatf("done_cnt len=%0d", v.len), done_cnt, 1);
        if (v.exp_done >= 0) check($sformatf("done_off len=%0d", v.len), done_off, v.exp_done);
        check($sformatf("first_valid len=%0d", v.len), first_valid, v.exp_first);
        check($sformatf("rx len=%0d", v.len), rx, v.len);
        check($sformatf("leftover len=%0d", v.len), exp_q.size(), 0);
        check($sformatf("busy_after len=%0d", v.len), int'(busy), 0);
        check($sformatf("ahead_le2 len=%0d", v.len), int'(max_ahead <= 2), 1);
        if (v.len == 0) check("busy_seen len=0", busy_seen, 0);
        mon_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0A00 + 16'(i);

        vecs[0] = '{5,  0, -1,  8,  3};
        vecs[1] = '{8,  1, -1, -1,  3};
        vecs[2] = '{0,  0, -1,  1, -1};
        vecs[3] = '{64, 0, -1, 67,  3};
        vecs[4] = '{10, 0,  4, 13,  3};
        vecs[5] = '{3,  2, -1,  8,  3};
        vecs[6] = '{7,  3, -1, -1,  3};
        vecs[7] = '{1,  0, -1,  4,  3};

        repeat (2) @(negedge clk);
        check("rst read_addr", int'(read_addr), 0);
        check("rst data", int'(data), 0);
        check("rst valid", int'(valid), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 8; n++) run_vec(vecs[n]);

        // Abort with rst while the fourth word sits on the output.
        @(posedge clk); #1;
        begin_burst(10);
        ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort valid", int'(valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort rx", rx, 3);
        mon_en = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        check("post-abort valid", int'(valid), 0);
        run_vec('{2, 0, -1, 5, 3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
